// File: rtl/bitmap_enc128.sv
// bitmap_enc128: serialises a multi-hot bitmap into a stream of set-bit
// indices, lowest index first, one beat per cycle under valid/ready flow
// control. An all-zero bitmap produces a single "none" beat.
module bitmap_enc128 #(
    parameter int W  = 128,
    parameter int IW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          out_none
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]    state;
    logic [W-1:0]  rem;
    logic          none;
    logic [IW-1:0] low_idx;
    logic          single;
    logic          emitting;
    logic          handshake;

    // Priority encoder: lowest-numbered set bit of rem wins.
    always_comb begin
        // NOTE: a default before the loop keeps this purely combinational;
        // without it a zero rem would leave low_idx unassigned (a latch).
        low_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (rem[i]) begin
                low_idx = IW'(i);
            end
        end
    end

    // Output decode: everything is forced to zero outside EMIT.
    always_comb begin
        emitting  = (state == EMIT);
        single    = (rem != '0) && ((rem & (rem - W'(1))) == '0);
        in_ready  = (state == IDLE);
        out_valid = emitting;
        out_idx   = (emitting && !none) ? low_idx : '0;
        out_last  = emitting && (none || single);
        out_none  = emitting && none;
        handshake = emitting && out_ready;
    end

    // State, remaining-bits and none-flag update; flush outranks everything.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: rem is a plain register, not a memory array, so resetting
            // it is cheap and guarantees no stale beats survive a reset.
            state <= IDLE;
            rem   <= '0;
            none  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            rem   <= '0;
            none  <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                state <= EMIT;
                rem   <= in_vec;
                none  <= (in_vec == '0);
            end
        end else if (handshake) begin
            if (out_last) begin
                state <= IDLE;
                rem   <= '0;
                none  <= 1'b0;
            end else begin
                // Clearing the lowest set bit is the same as clearing out_idx.
                rem <= rem & (rem - W'(1));
            end
        end
    end

endmodule

// File: tb/tb_bitmap_enc128.sv
// tb_bitmap_enc128: directed scenarios with literal expectations, then a
// randomized run; a queue-based model of the beat stream is compared against
// the DUT on every falling clock edge.
module tb_bitmap_enc128;

    localparam int W  = 128;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_none;

    int errors = 0;
    int checks = 0;

    bitmap_enc128 #(.W(W), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic beat(input string name, input bit v, input int idx, input bit last, input bit nn);
        check({name, ".in_ready"},  32'(in_ready),  32'(!v));
        check({name, ".out_valid"}, 32'(out_valid), 32'(v));
        check({name, ".out_idx"},   32'(out_idx),   32'(idx));
        check({name, ".out_last"},  32'(out_last),  32'(last));
        check({name, ".out_none"},  32'(out_none),  32'(nn));
    endtask

    // Reference model: the list of indices still to be emitted for the
    // vector in flight; empty means the block is waiting for input.
    int q[$];
    bit m_none;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_none = 1'b0;
        end else if (flush) begin
            q.delete();
            m_none = 1'b0;
        end else if (q.size() == 0) begin
            if (in_valid) begin
                m_none = (in_vec == '0);
                if (m_none) q.push_back(0);
                else for (int i = 0; i < W; i++) if (in_vec[i]) q.push_back(i);
            end
        end else if (out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) m_none = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [10:0] exp_v;
        logic [10:0] act_v;
        if (q.size() != 0)
            exp_v = {1'b0, 1'b1, IW'(q[0]), (q.size() == 1), m_none};
        else
            exp_v = {1'b1, 1'b0, {IW{1'b0}}, 1'b0, 1'b0};
        act_v = {in_ready, out_valid, out_idx, out_last, out_none};
        check("cycle_cmp", 32'(act_v), 32'(exp_v));
    end

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] a, b;
        int mode;
        for (int k = 0; k < W / 32; k++) begin
            a[k*32 +: 32] = $urandom;
            b[k*32 +: 32] = $urandom;
        end
        mode = $urandom_range(0, 3);
        case (mode)
            0: return '0;
            1: begin
                logic [W-1:0] s;
                s = '0;
                for (int k = 0; k < 3; k++) s[$urandom_range(0, W - 1)] = 1'b1;
                return s;
            end
            2: return a & b;
            default: return a;
        endcase
    endfunction

    initial begin
        logic [W-1:0] v;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
        #1;
        beat("reset", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Bits {0,5,127}: three back-to-back beats, last on 127.
        @(negedge clk);
        v = '0; v[0] = 1'b1; v[5] = 1'b1; v[127] = 1'b1;
        in_vec = v; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        beat("b3_0", 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk); beat("b3_5", 1'b1, 5, 1'b0, 1'b0);
        @(negedge clk); beat("b3_127", 1'b1, 127, 1'b1, 1'b0);
        @(negedge clk); beat("b3_idle", 1'b0, 0, 1'b0, 1'b0);

        // Zero vector: a single none beat.
        in_vec = '0; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        beat("zero", 1'b1, 0, 1'b1, 1'b1);
        @(negedge clk); beat("zero_idle", 1'b0, 0, 1'b0, 1'b0);

        // 0x0C with backpressure: idx 2 held for three cycles.
        v = '0; v[2] = 1'b1; v[3] = 1'b1;
        in_vec = v; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        beat("bp_hold0", 1'b1, 2, 1'b0, 1'b0);
        @(negedge clk); beat("bp_hold1", 1'b1, 2, 1'b0, 1'b0);
        @(negedge clk); beat("bp_hold2", 1'b1, 2, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk); beat("bp_3", 1'b1, 3, 1'b1, 1'b0);
        @(negedge clk); beat("bp_idle", 1'b0, 0, 1'b0, 1'b0);

        // All ones: 128 consecutive beats.
        in_vec = '1; in_valid = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk); in_valid = 1'b0;
            beat("ones", 1'b1, i, (i == W - 1), 1'b0);
        end
        @(negedge clk); beat("ones_idle", 1'b0, 0, 1'b0, 1'b0);

        // Bits {1,2,3}: reset after beat 1 discards the rest.
        v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1;
        in_vec = v; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        beat("rst_b1", 1'b1, 1, 1'b0, 1'b0);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 beat("rst_async", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk); beat("rst_after0", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk); beat("rst_after1", 1'b0, 0, 1'b0, 1'b0);

        // Bits {4,9}: flush during beat 4 while a new vector is offered.
        v = '0; v[4] = 1'b1; v[9] = 1'b1;
        in_vec = v; in_valid = 1'b1;
        @(negedge clk);
        beat("fl_b4", 1'b1, 4, 1'b0, 1'b0);
        flush = 1'b1; in_vec = 128'hF0;
        @(negedge clk);
        beat("fl_idle", 1'b0, 0, 1'b0, 1'b0);
        // Flush in IDLE must also block acceptance.
        @(negedge clk);
        beat("fl_idle_blk", 1'b0, 0, 1'b0, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); beat("fl_done", 1'b0, 0, 1'b0, 1'b0);

        // Randomized traffic checked by the per-cycle comparison.
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_vec    = rand_vec();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
